// File: rtl/divisor_fixed_seq_pkg.sv
// Shared fixed-point helpers: FSM state type, S(N,F) limit constants and
// the shift/iteration-count derivation used by the divider.
package divisor_fixed_seq_pkg;

  typedef enum logic [1:0] {IDLE, DIV, FIN, DONE} state_t;

  // Largest positive code of an N-bit signed word.
  function automatic int smax_f(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  // Magnitude of the most negative code of an N-bit signed word.
  function automatic int sminmag_f(input int n);
    return 1 << (n - 1);
  endfunction

  // Left shift that aligns A's binary point to Q once divided by B.
  function automatic int sh_f(input int nbfa, input int nbfb, input int nbfq);
    return nbfq + nbfb - nbfa;
  endfunction

  // Integer quotient bits plus one guard bit.
  function automatic int nit_f(input int nba, input int sh);
    return nba + sh + 1;
  endfunction

endpackage

// File: rtl/divisor_fixed_seq_if.sv
// Operand/result valid-ready bundle for the fixed-point divider.
interface divisor_fixed_seq_if #(
  parameter int NBA = 12,
  parameter int NBB = 8,
  parameter int NBQ = 10
);
  logic           i_valid;
  logic           o_ready;
  logic [NBA-1:0] i_saa_aa;
  logic [NBB-1:0] i_sbb_bb;
  logic           o_valid;
  logic           i_ready;
  logic [NBQ-1:0] o_sqq_qq;
  logic           o_sat;
  logic           o_div_zero;

  modport master (
    output i_valid, i_saa_aa, i_sbb_bb, i_ready,
    input  o_ready, o_valid, o_sqq_qq, o_sat, o_div_zero
  );

  modport slave (
    input  i_valid, i_saa_aa, i_sbb_bb, i_ready,
    output o_ready, o_valid, o_sqq_qq, o_sat, o_div_zero
  );
endinterface

// File: rtl/divisor_fixed_seq_step.sv
// Unsigned restoring divider core: one quotient bit per clock, MSB first.
// 'last' is high during the cycle whose edge performs the final iteration.
module div_restoring_step_u #(
  parameter int NIT = 17,
  parameter int NBD = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [NIT-1:0] dividend,
  input  logic [NBD-1:0] divisor,
  output logic [NIT-1:0] quot,
  output logic           last
);
  localparam int CW = (NIT > 1) ? $clog2(NIT) : 1;

  logic [NIT-1:0] dvd;
  logic [NBD-1:0] dsr, rem, rem_n;
  logic [CW-1:0]  cnt;
  logic           busy;
  logic [NBD:0]   trial, diff;
  logic           ge;

  // rem < dsr always holds, so the restored or reduced remainder fits NBD bits.
  always_comb begin
    trial = {rem, dvd[NIT-1]};
    diff  = trial - {1'b0, dsr};
    ge    = trial >= {1'b0, dsr};
    rem_n = NBD'(ge ? diff : trial);
  end

  assign last = busy && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd  <= '0;
      dsr  <= '0;
      rem  <= '0;
      quot <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      dvd  <= dividend;
      dsr  <= divisor;
      rem  <= '0;
      quot <= '0;
      cnt  <= CW'(NIT - 1);
      busy <= 1'b1;
    end else if (busy) begin
      dvd  <= dvd << 1;
      rem  <= rem_n;
      quot <= {quot[NIT-2:0], ge};
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/divisor_fixed_seq.sv
// Sequential signed fixed-point divider Q = A / B with round/saturate stage.
// Define DIVISOR_FIXED_ROUND_EN to round on the guard bit; otherwise truncate.
module divisor_fixed_seq
  import divisor_fixed_seq_pkg::*;
#(
  parameter int NBA  = 12,
  parameter int NBFA = 11,
  parameter int NBB  = 8,
  parameter int NBFB = 6,
  parameter int NBQ  = 10,
  parameter int NBFQ = 9
) (
  input  logic               i_clock,
  input  logic               i_reset,
  divisor_fixed_seq_if.slave bus
);
  localparam int SH  = sh_f(NBFA, NBFB, NBFQ);
  localparam int NIT = nit_f(NBA, SH);
  localparam logic [NIT-1:0] POS_LIM = NIT'(smax_f(NBQ));
  localparam logic [NIT-1:0] NEG_LIM = NIT'(sminmag_f(NBQ));
  localparam logic [NBQ-1:0] POS_Q   = NBQ'(smax_f(NBQ));
  localparam logic [NBQ-1:0] NEG_Q   = {1'b1, {(NBQ-1){1'b0}}};
`ifdef DIVISOR_FIXED_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  if (NBFQ + NBFB < NBFA) begin : g_bad_fmt
    $error("divisor_fixed_seq: NBFQ+NBFB must be >= NBFA");
  end

  state_t         state;
  logic           rdy, vld, sat, dz, sgn, aneg, dzr;
  logic [NBQ-1:0] q;

  logic [NBA:0]   a_ext, amag;
  logic [NBB:0]   b_ext, bmag;
  logic [NIT-1:0] dvd_in, raw, mag_r, mag_s;
  logic           accept, core_last, sat_c;
  logic [NBQ-1:0] q_c;

  // One extra bit so the most negative operand has a representable magnitude.
  assign a_ext  = {bus.i_saa_aa[NBA-1], bus.i_saa_aa};
  assign b_ext  = {bus.i_sbb_bb[NBB-1], bus.i_sbb_bb};
  assign amag   = a_ext[NBA] ? -a_ext : a_ext;
  assign bmag   = b_ext[NBB] ? -b_ext : b_ext;
  assign dvd_in = NIT'(amag) << (SH + 1);
  assign accept = (state == IDLE) && bus.i_valid && rdy;

  div_restoring_step_u #(.NIT(NIT), .NBD(NBB + 1)) u_core (
    .clk      (i_clock),
    .rst      (i_reset),
    .start    (accept && (bmag != '0)),
    .dividend (dvd_in),
    .divisor  (bmag),
    .quot     (raw),
    .last     (core_last)
  );

  // Raw carries one extra LSB; it becomes the round-half-away increment.
  always_comb begin
    mag_r = (raw >> 1) + {{(NIT-1){1'b0}}, RND & raw[0]};
    mag_s = mag_r;
    sat_c = 1'b0;
    if (!sgn && mag_r > POS_LIM) begin
      mag_s = POS_LIM;
      sat_c = 1'b1;
    end else if (sgn && mag_r > NEG_LIM) begin
      mag_s = NEG_LIM;
      sat_c = 1'b1;
    end
    q_c = NBQ'(sgn ? (~mag_s + NIT'(1)) : mag_s);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      rdy   <= 1'b1;
      vld   <= 1'b0;
      q     <= '0;
      sat   <= 1'b0;
      dz    <= 1'b0;
      sgn   <= 1'b0;
      aneg  <= 1'b0;
      dzr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sgn   <= a_ext[NBA] ^ b_ext[NBB];
          aneg  <= a_ext[NBA];
          dzr   <= (bmag == '0);
          rdy   <= 1'b0;
          state <= DIV;
        end
        DIV: if (dzr || core_last) state <= FIN;
        FIN: begin
          vld   <= 1'b1;
          state <= DONE;
          if (dzr) begin
            q   <= aneg ? NEG_Q : POS_Q;
            sat <= 1'b1;
            dz  <= 1'b1;
          end else begin
            q   <= q_c;
            sat <= sat_c;
            dz  <= 1'b0;
          end
        end
        DONE: if (bus.i_ready) begin
          vld   <= 1'b0;
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready    = rdy;
  assign bus.o_valid    = vld;
  assign bus.o_sqq_qq   = q;
  assign bus.o_sat      = sat;
  assign bus.o_div_zero = dz;
endmodule

// File: tb/tb_divisor_fixed_seq.sv
// Directed-vector bench for divisor_fixed_seq at default parameters.
module tb_divisor_fixed_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divisor_fixed_seq_if #(.NBA(12), .NBB(8), .NBQ(10)) bus ();

  divisor_fixed_seq dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

`ifdef DIVISOR_FIXED_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [11:0] a;
    logic [7:0]  b;
    logic [9:0]  qr;   // expected with rounding
    logic [9:0]  qt;   // expected with truncation
    logic        sat;
    logic        dz;
    int          lat;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  int ncmp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present operands, return cycles from acceptance edge to o_valid.
  task automatic op(input logic [11:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    chk("ready_before_op", 32'(bus.o_ready), 32'd1);
    bus.i_saa_aa = a;
    bus.i_sbb_bb = b;
    bus.i_valid  = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    lat = 0;
    while (!bus.o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    nvec++;
  endtask

  task automatic rel();
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", 32'(bus.o_valid), 32'd0);
    bus.i_ready = 1'b0;
  endtask

  initial begin
    vec_t tbl[15];
    int   lat;
    logic [9:0] hold_q;

    tbl[0]  = '{12'h400, 8'h40, 10'h100, 10'h100, 1'b0, 1'b0, 18};
    tbl[1]  = '{12'hC00, 8'h10, 10'h200, 10'h200, 1'b1, 1'b0, 18};
    tbl[2]  = '{12'h400, 8'h00, 10'h1FF, 10'h1FF, 1'b1, 1'b1, 2};
    tbl[3]  = '{12'hC00, 8'h00, 10'h200, 10'h200, 1'b1, 1'b1, 2};
    tbl[4]  = '{12'h002, 8'h40, 10'h001, 10'h000, 1'b0, 1'b0, 18};
    tbl[5]  = '{12'hFFE, 8'h40, 10'h3FF, 10'h000, 1'b0, 1'b0, 18};
    tbl[6]  = '{12'h000, 8'h25, 10'h000, 10'h000, 1'b0, 1'b0, 18};
    tbl[7]  = '{12'h7FF, 8'h7F, 10'h102, 10'h101, 1'b0, 1'b0, 18};
    tbl[8]  = '{12'h800, 8'h80, 10'h100, 10'h100, 1'b0, 1'b0, 18};
    tbl[9]  = '{12'h800, 8'h01, 10'h200, 10'h200, 1'b1, 1'b0, 18};
    tbl[10] = '{12'h7FF, 8'h01, 10'h1FF, 10'h1FF, 1'b1, 1'b0, 18};
    tbl[11] = '{12'h100, 8'hC0, 10'h3C0, 10'h3C0, 1'b0, 1'b0, 18};
    tbl[12] = '{12'h3FF, 8'h40, 10'h100, 10'h0FF, 1'b0, 1'b0, 18};
    tbl[13] = '{12'h800, 8'h40, 10'h200, 10'h200, 1'b0, 1'b0, 18};
    tbl[14] = '{12'h400, 8'h20, 10'h1FF, 10'h1FF, 1'b1, 1'b0, 18};

    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b0;
    bus.i_saa_aa = '0;
    bus.i_sbb_bb = '0;

    #12;
    chk("rst_ready", 32'(bus.o_ready),    32'd1);
    chk("rst_valid", 32'(bus.o_valid),    32'd0);
    chk("rst_q",     32'(bus.o_sqq_qq),   32'd0);
    chk("rst_sat",   32'(bus.o_sat),      32'd0);
    chk("rst_dz",    32'(bus.o_div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      op(tbl[i].a, tbl[i].b, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat),            32'(tbl[i].lat));
      chk($sformatf("v%0d_q", i),   32'(bus.o_sqq_qq),   32'(RND ? tbl[i].qr : tbl[i].qt));
      chk($sformatf("v%0d_sat", i), 32'(bus.o_sat),      32'(tbl[i].sat));
      chk($sformatf("v%0d_dz", i),  32'(bus.o_div_zero), 32'(tbl[i].dz));
      rel();
    end

    // Backpressure: result held, new operands ignored until back in IDLE.
    op(12'h400, 8'h40, lat);
    chk("bp_q0", 32'(bus.o_sqq_qq), 32'h100);
    @(negedge clk);
    bus.i_saa_aa = 12'h100;
    bus.i_sbb_bb = 8'hC0;
    bus.i_valid  = 1'b1;
    hold_q = bus.o_sqq_qq;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_q",     32'(bus.o_sqq_qq), 32'(hold_q));
      chk("bp_hold_valid", 32'(bus.o_valid),  32'd1);
      chk("bp_hold_ready", 32'(bus.o_ready),  32'd0);
    end
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    chk("bp_rel_valid", 32'(bus.o_valid), 32'd0);
    chk("bp_rel_ready", 32'(bus.o_ready), 32'd1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    lat = 0;
    while (!bus.o_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    nvec++;
    chk("bp2_lat", 32'(lat),          32'd18);
    chk("bp2_q",   32'(bus.o_sqq_qq), 32'h3C0);
    chk("bp2_sat", 32'(bus.o_sat),    32'd0);
    rel();

    // Reset during DIV iteration 8 drops the in-flight operation.
    @(negedge clk);
    bus.i_saa_aa = 12'h400;
    bus.i_sbb_bb = 8'h40;
    bus.i_valid  = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    nvec++;
    repeat (8) @(posedge clk);
    #2;
    chk("div_ready_low", 32'(bus.o_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.o_valid), 32'd0);
    chk("midrst_ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    op(12'h3FF, 8'h40, lat);
    chk("postrst_lat", 32'(lat),          32'd18);
    chk("postrst_q",   32'(bus.o_sqq_qq), 32'(RND ? 10'h100 : 10'h0FF));
    rel();

    // Reset while a saturated result waits in DONE clears outputs at once.
    op(12'h7FF, 8'h01, lat);
    chk("done_sat", 32'(bus.o_sat), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("donerst_valid", 32'(bus.o_valid),    32'd0);
    chk("donerst_q",     32'(bus.o_sqq_qq),   32'd0);
    chk("donerst_sat",   32'(bus.o_sat),      32'd0);
    chk("donerst_dz",    32'(bus.o_div_zero), 32'd0);
    chk("donerst_ready", 32'(bus.o_ready),    32'd1);
    @(negedge clk);
    rst = 1'b0;
    op(12'hC00, 8'h00, lat);
    chk("final_lat", 32'(lat),            32'd2);
    chk("final_q",   32'(bus.o_sqq_qq),   32'h200);
    chk("final_dz",  32'(bus.o_div_zero), 32'd1);
    rel();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
